// File: rtl/cmd_reply_pkg.sv
// Shared types and constants for the command reply packet buffer.
// Optional build macro: CMD_REPLY_LEN_HDR_EN (word 0 of each packet carries the reply length).
package cmd_reply_pkg;

  localparam int PKT_WORDS = 256;
  localparam int WORD_AW   = 8;

  typedef enum logic [1:0] {
    WS_IDLE   = 2'd0,
    WS_FILL   = 2'd1,
    WS_PAD    = 2'd2,
    WS_COMMIT = 2'd3
  } wstate_t;

  localparam logic [15:0] PAD_WORD = 16'h0000;

  localparam int HDR_LEN_W = 9;
  localparam int HDR_RSV_W = 7;

`ifdef CMD_REPLY_LEN_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  // Number of reply words one packet can carry.
  localparam logic [8:0] PAYLOAD_CAP = 9'(PKT_WORDS - HDR_WORDS);

  function automatic logic [15:0] make_hdr(input logic [HDR_LEN_W-1:0] len);
    return {{HDR_RSV_W{1'b0}}, len};
  endfunction

endpackage

// File: rtl/reply_slot_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset so the storage array can map onto block RAM.
module reply_slot_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  parameter int AW    = 9
) (
  input  logic             txclk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge txclk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/cmd_reply_buffer.sv
// Packs command-reader replies into fixed 256-word packets and queues them for the RX arbiter.
// Optional build macro: CMD_REPLY_LEN_HDR_EN (length header in word 0, two-cycle commit).
module cmd_reply_buffer
  import cmd_reply_pkg::*;
#(
  parameter int NUM_PKTS = 2,
  parameter int PTR_W    = 1
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  input  logic        RD,
  input  logic        RD_done,
  output logic [15:0] dataout,
  output logic        pkt_waiting,
  output logic        have_space,
  output logic        overflow,
  input  logic        clear_status,
  output logic [15:0] debug
);

  localparam int AW    = PTR_W + WORD_AW;
  localparam int DBG_W = 11 + 3 * PTR_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(NUM_PKTS);

  wstate_t          wstate_r;
  logic [PTR_W-1:0] wr_slot_r, rd_slot_r;
  logic [PTR_W:0]   count_r, count_nxt_s;
  logic [8:0]       wr_addr_r, fill_cnt_s;
  logic [7:0]       rd_addr_r, wr_phys_s;
  logic             overflow_r, rx_wr_enabled_r, pkt_waiting_r, have_space_r;
  logic [15:0]      debug_r, dbg_s;
  logic [DBG_W-1:0] dbg_raw_s;
  logic             space_s, waiting_s, slot_full_s;
  logic             ram_we_s, drop_s, commit_fire_s, rd_fire_s, rd_rel_s;
  logic [AW-1:0]    ram_waddr_s;
  logic [15:0]      ram_wdata_s;
`ifdef CMD_REPLY_LEN_HDR_EN
  logic             hdr_phase_r;
  logic [8:0]       len_r;
`endif

  assign space_s     = (count_r != FULL_CNT);
  assign waiting_s   = (count_r != {(PTR_W + 1){1'b0}});
  assign slot_full_s = (wr_addr_r == PAYLOAD_CAP);
  assign wr_phys_s   = wr_addr_r[7:0] + 8'(HDR_WORDS);
  assign fill_cnt_s  = wr_addr_r + {8'd0, ram_we_s};
  assign rd_fire_s   = RD && waiting_s;
  assign rd_rel_s    = RD_done && waiting_s;

  // Write-port steering, drop detection and commit strobe for the writer FSM.
  always_comb begin
    ram_we_s      = 1'b0;
    ram_waddr_s   = {wr_slot_r, wr_phys_s};
    ram_wdata_s   = rx_databus;
    drop_s        = 1'b0;
    commit_fire_s = 1'b0;
    case (wstate_r)
      WS_IDLE: begin
        if (rx_WR) begin
          ram_we_s = space_s;
          drop_s   = !space_s;
        end else begin
          ram_we_s = 1'b0;
        end
      end
      WS_FILL: begin
        if (rx_WR) begin
          ram_we_s = !slot_full_s;
          drop_s   = slot_full_s;
        end else begin
          ram_we_s = 1'b0;
        end
      end
      WS_PAD: begin
        ram_we_s    = 1'b1;
        ram_wdata_s = PAD_WORD;
        drop_s      = rx_WR;
      end
      WS_COMMIT: begin
        drop_s = rx_WR;
`ifdef CMD_REPLY_LEN_HDR_EN
        if (!hdr_phase_r) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = {wr_slot_r, 8'd0};
          ram_wdata_s = make_hdr(len_r);
        end else begin
          commit_fire_s = 1'b1;
        end
`else
        commit_fire_s = 1'b1;
`endif
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Committed-packet count: a commit and a release in the same cycle cancel.
  always_comb begin
    count_nxt_s = count_r;
    case ({commit_fire_s, rd_rel_s})
      2'b10:   count_nxt_s = count_r + (PTR_W + 1)'(1'b1);
      2'b01:   count_nxt_s = count_r - (PTR_W + 1)'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Writer FSM: assemble, pad and commit one packet at a time.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      wstate_r  <= WS_IDLE;
      wr_addr_r <= 9'd0;
      wr_slot_r <= {PTR_W{1'b0}};
`ifdef CMD_REPLY_LEN_HDR_EN
      hdr_phase_r <= 1'b0;
      len_r       <= 9'd0;
`endif
    end else begin
      case (wstate_r)
        WS_IDLE, WS_FILL: begin
          if (ram_we_s) begin
            wr_addr_r <= fill_cnt_s;
          end
          if (rx_WR_done && (wstate_r == WS_FILL || space_s)) begin
`ifdef CMD_REPLY_LEN_HDR_EN
            len_r <= fill_cnt_s;
`endif
            // A reply that exactly fills the slot needs no padding.
            wstate_r <= (fill_cnt_s == PAYLOAD_CAP) ? WS_COMMIT : WS_PAD;
          end else if (ram_we_s) begin
            wstate_r <= WS_FILL;
          end
        end
        WS_PAD: begin
          wr_addr_r <= wr_addr_r + 9'd1;
          if (wr_addr_r == PAYLOAD_CAP - 9'd1) begin
            wstate_r <= WS_COMMIT;
          end
        end
        WS_COMMIT: begin
`ifdef CMD_REPLY_LEN_HDR_EN
          hdr_phase_r <= !hdr_phase_r;
`endif
          if (commit_fire_s) begin
            wr_slot_r <= wr_slot_r + PTR_W'(1'b1);
            wr_addr_r <= 9'd0;
            wstate_r  <= WS_IDLE;
          end
        end
        default: wstate_r <= WS_IDLE;
      endcase
    end
  end

  // Reader pointers and the queue count.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      rd_slot_r <= {PTR_W{1'b0}};
      rd_addr_r <= 8'd0;
      count_r   <= {(PTR_W + 1){1'b0}};
    end else begin
      count_r <= count_nxt_s;
      if (rd_rel_s) begin
        rd_slot_r <= rd_slot_r + PTR_W'(1'b1);
        rd_addr_r <= 8'd0;
      end else if (rd_fire_s && rd_addr_r != 8'hFF) begin
        rd_addr_r <= rd_addr_r + 8'd1;
      end
    end
  end

  assign dbg_raw_s = {wstate_r, wr_slot_r, rd_slot_r, count_r, wr_addr_r[7:0]};
  generate
    if (DBG_W <= 16) begin : g_dbg_fill
      assign dbg_s = {dbg_raw_s, {(16 - DBG_W){1'b0}}};
    end else begin : g_dbg_trunc
      assign dbg_s = dbg_raw_s[DBG_W-1 -: 16];
    end
  endgenerate

  // Registered status outputs.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      rx_wr_enabled_r <= 1'b0;
      pkt_waiting_r   <= 1'b0;
      have_space_r    <= 1'b0;
      overflow_r      <= 1'b0;
      debug_r         <= 16'h0000;
    end else begin
      rx_wr_enabled_r <= (wstate_r == WS_IDLE || wstate_r == WS_FILL) && space_s;
      pkt_waiting_r   <= (count_nxt_s != {(PTR_W + 1){1'b0}});
      have_space_r    <= (count_nxt_s != FULL_CNT);
      if (clear_status) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
      debug_r <= dbg_s;
    end
  end

  reply_slot_ram #(
    .DEPTH(NUM_PKTS * PKT_WORDS),
    .WIDTH(16),
    .AW   (AW)
  ) u_ram (
    .txclk(txclk),
    .reset(reset),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .re   (rd_fire_s),
    .raddr({rd_slot_r, rd_addr_r}),
    .rdata(dataout)
  );

  assign rx_WR_enabled = rx_wr_enabled_r;
  assign pkt_waiting   = pkt_waiting_r;
  assign have_space    = have_space_r;
  assign overflow      = overflow_r;
  assign debug         = debug_r;

endmodule

// File: tb/tb_cmd_reply_buffer.sv
// Directed self-checking bench for cmd_reply_buffer (default build, two packet slots).
module tb_cmd_reply_buffer;

  logic        txclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rx_databus = 16'h0000;
  logic        rx_WR = 1'b0, rx_WR_done = 1'b0, RD = 1'b0, RD_done = 1'b0, clear_status = 1'b0;
  logic        rx_WR_enabled, pkt_waiting, have_space, overflow;
  logic [15:0] dataout, debug;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_mem [256];

  cmd_reply_buffer dut (
    .txclk(txclk), .reset(reset), .rx_databus(rx_databus), .rx_WR(rx_WR),
    .rx_WR_done(rx_WR_done), .rx_WR_enabled(rx_WR_enabled), .RD(RD), .RD_done(RD_done),
    .dataout(dataout), .pkt_waiting(pkt_waiting), .have_space(have_space),
    .overflow(overflow), .clear_status(clear_status), .debug(debug)
  );

  always #5 txclk = ~txclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Words base, base+step, ... then a separate done pulse.
  task automatic send_reply(input int n, input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < n; i++) begin
      rx_WR = 1'b1;
      rx_databus = base + 16'(step * i);
      @(negedge txclk);
    end
    rx_WR = 1'b0;
    rx_WR_done = 1'b1;
    @(negedge txclk);
    rx_WR_done = 1'b0;
  endtask

  task automatic wait_pkt(input string tag, output int cycles);
    cycles = 0;
    while (pkt_waiting !== 1'b1 && cycles < 400) begin
      @(negedge txclk);
      cycles++;
    end
    chk(tag, {15'd0, pkt_waiting}, 16'h0001);
  endtask

  task automatic read_chk(input string tag, input int n);
    RD = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge txclk);
      if (i == n - 1) RD = 1'b0;
      chk($sformatf("%s[%0d]", tag, i), dataout, exp_mem[i]);
    end
  endtask

  task automatic pulse_rd_done();
    RD_done = 1'b1;
    @(negedge txclk);
    RD_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int c;
    // Reset state
    repeat (2) @(negedge txclk);
    chk("rst_dataout", dataout, 16'h0000);
    chk("rst_pkt", {15'd0, pkt_waiting}, 16'h0000);
    chk("rst_space", {15'd0, have_space}, 16'h0000);
    chk("rst_en", {15'd0, rx_WR_enabled}, 16'h0000);
    chk("rst_ovf", {15'd0, overflow}, 16'h0000);
    chk("rst_debug", debug, 16'h0000);
    reset = 1'b0;
    @(negedge txclk);
    chk("idle_space", {15'd0, have_space}, 16'h0001);
    chk("idle_en", {15'd0, rx_WR_enabled}, 16'h0001);

    // Three-word reply, zero padded
    send_reply(3, 16'h00A1, 16'h0111);
    wait_pkt("t1_pkt", cyc);
    chk("t1_latency_ok", {15'd0, cyc <= 258}, 16'h0001);
    for (int i = 0; i < 256; i++) exp_mem[i] = (i < 3) ? 16'h00A1 + 16'(16'h0111 * i) : 16'h0000;
    read_chk("t1_rd", 256);
    pulse_rd_done();
    chk("t1_pkt_gone", {15'd0, pkt_waiting}, 16'h0000);

    // Both slots full
    send_reply(1, 16'h1111, 16'h0000);
    wait_pkt("t2_pkt1", cyc);
    send_reply(1, 16'h2222, 16'h0000);
    c = 0;
    while (have_space !== 1'b0 && c < 400) begin
      @(negedge txclk);
      c++;
    end
    chk("t2_full_space", {15'd0, have_space}, 16'h0000);
    @(negedge txclk);
    chk("t2_full_en", {15'd0, rx_WR_enabled}, 16'h0000);
    chk("t2_ovf_before", {15'd0, overflow}, 16'h0000);
    rx_WR = 1'b1;
    rx_databus = 16'hDEAD;
    @(negedge txclk);
    rx_WR = 1'b0;
    chk("t2_ovf_set", {15'd0, overflow}, 16'h0001);
    clear_status = 1'b1;
    @(negedge txclk);
    clear_status = 1'b0;
    chk("t2_ovf_clr", {15'd0, overflow}, 16'h0000);
    pulse_rd_done();
    chk("t2_space_back", {15'd0, have_space}, 16'h0001);
    chk("t2_en_lag", {15'd0, rx_WR_enabled}, 16'h0000);
    @(negedge txclk);
    chk("t2_en_back", {15'd0, rx_WR_enabled}, 16'h0001);
    exp_mem[0] = 16'h2222;
    read_chk("t2_rd", 1);
    pulse_rd_done();

    // 300-word reply: 256 stored, one packet
    send_reply(300, 16'h4000, 16'h0001);
    wait_pkt("t3_pkt", cyc);
    repeat (2) @(negedge txclk);
    chk("t3_ovf", {15'd0, overflow}, 16'h0001);
    chk("t3_one_pkt", {15'd0, have_space}, 16'h0001);
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'h4000 + 16'(i);
    read_chk("t3_rd", 256);
    pulse_rd_done();
    chk("t3_pkt_gone", {15'd0, pkt_waiting}, 16'h0000);
    clear_status = 1'b1;
    @(negedge txclk);
    clear_status = 1'b0;

    // Commit coincides with RD_done
    send_reply(1, 16'h5151, 16'h0000);
    wait_pkt("t4_pkt1", cyc);
    @(negedge txclk);
    rx_WR = 1'b1;
    rx_databus = 16'h6161;
    @(negedge txclk);
    rx_databus = 16'h6262;
    rx_WR_done = 1'b1;
    @(negedge txclk);
    rx_WR = 1'b0;
    rx_WR_done = 1'b0;
    repeat (254) @(negedge txclk);
    pulse_rd_done();
    chk("t4_pkt", {15'd0, pkt_waiting}, 16'h0001);
    chk("t4_space", {15'd0, have_space}, 16'h0001);
    @(negedge txclk);
    chk("t4_debug", debug, 16'h1400);
    exp_mem[0] = 16'h6161;
    exp_mem[1] = 16'h6262;
    read_chk("t4_rd", 2);
    pulse_rd_done();

    // RD / RD_done with nothing queued
    RD = 1'b1;
    RD_done = 1'b1;
    @(negedge txclk);
    RD = 1'b0;
    RD_done = 1'b0;
    chk("t5_hold", dataout, 16'h6262);
    chk("t5_pkt", {15'd0, pkt_waiting}, 16'h0000);
    chk("t5_space", {15'd0, have_space}, 16'h0001);
    @(negedge txclk);
    chk("t5_debug", debug, 16'h0000);

    // Asynchronous reset mid-FILL
    rx_WR = 1'b1;
    rx_databus = 16'h9999;
    @(negedge txclk);
    rx_databus = 16'h8888;
    @(posedge txclk);
    #2;
    reset = 1'b1;
    rx_WR = 1'b0;
    #1;
    chk("t6_dataout", dataout, 16'h0000);
    chk("t6_space", {15'd0, have_space}, 16'h0000);
    chk("t6_en", {15'd0, rx_WR_enabled}, 16'h0000);
    chk("t6_debug", debug, 16'h0000);
    @(negedge txclk);
    reset = 1'b0;
    @(negedge txclk);
    send_reply(1, 16'h7777, 16'h0000);
    wait_pkt("t6_pkt", cyc);
    @(negedge txclk);
    chk("t6_debug_ptrs", debug, 16'h2400);
    exp_mem[0] = 16'h7777;
    exp_mem[1] = 16'h0000;
    read_chk("t6_rd", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
